// File: rtl/add_normalise_pack.sv
// add_normalise_pack: back end of the HCORDIC floating-point adder.
// Takes the raw sum from the add stage, normalises it one bit per cycle,
// rounds and packs it into an IEEE-754 single-precision word.
// Both sides use a valid/ready handshake, so the variable-latency
// normalisation loop can sit inside an otherwise fixed pipeline.
// Optional feature macro: NORM_ROUND_EN
//   defined   -> round-to-nearest-even on the mantissa
//   undefined -> truncate (guard/round/sticky discarded, same latency)
module add_normalise_pack (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        idle_AddState,
  input  logic [31:0] sout_AddState,
  input  logic [27:0] sum_AddState,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Smallest normal exponent; below this the result stays denormal.
  localparam logic signed [9:0] EXP_MIN  = -10'sd126;
  localparam logic signed [9:0] EXP_BIAS = 10'sd127;
  localparam logic signed [9:0] EXP_INF  = 10'sd255;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [27:0]        sum_q, sum_d;
  logic [31:0]        result_q, result_d;

  logic               round_up;
  logic [24:0]        mant_inc;
  logic [23:0]        mant_rnd;
  logic signed [9:0]  exp_rnd;
  logic signed [9:0]  biased;
  logic [31:0]        packed_word;

  // Round the current mantissa, renormalise a rounding carry, then pack.
  always_comb begin
`ifdef NORM_ROUND_EN
    round_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
`else
    round_up = 1'b0;
`endif
    mant_inc = {1'b0, sum_q[26:3]} + {24'd0, round_up};
    if (mant_inc[24]) begin
      mant_rnd = mant_inc[24:1];
      exp_rnd  = exp_q + 10'sd1;
    end else begin
      mant_rnd = mant_inc[23:0];
      exp_rnd  = exp_q;
    end
    biased = exp_rnd + EXP_BIAS;
    if (biased >= EXP_INF) begin
      packed_word = {sign_q, 8'hFF, 23'd0};
    end else if (!mant_rnd[23]) begin
      packed_word = {sign_q, 8'h00, mant_rnd[22:0]};
    end else begin
      packed_word = {sign_q, biased[7:0], mant_rnd[22:0]};
    end
  end

  // Next-state logic: capture, one normalisation step per cycle, round, hand off.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    sum_d    = sum_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = sout_AddState[31];
          exp_d  = {{2{sout_AddState[30]}}, sout_AddState[30:23]};
          sum_d  = sum_AddState;
          if (idle_AddState) begin
            result_d = sout_AddState;
            state_d  = S_OUT;
          end else begin
            state_d  = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (sum_q == 28'd0) begin
          result_d = {sign_q, 31'd0};
          state_d  = S_OUT;
        end else if (sum_q[27]) begin
          sum_d = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
          exp_d = exp_q + 10'sd1;
        end else if (!sum_q[26] && (exp_q > EXP_MIN)) begin
          sum_d = {sum_q[26:0], 1'b0};
          exp_d = exp_q - 10'sd1;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        result_d = packed_word;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      sum_q    <= 28'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      sum_q    <= sum_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign result    = result_q;

endmodule

// File: tb/tb_add_normalise_pack.sv
// tb_add_normalise_pack: directed-vector bench for add_normalise_pack.
// Each scenario task drives its stimulus and checks results inline.
module tb_add_normalise_pack;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        idle_AddState;
  logic [31:0] sout_AddState;
  logic [27:0] sum_AddState;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int tests_run;
  int tests_failed;

  add_normalise_pack dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .idle_AddState (idle_AddState),
    .sout_AddState (sout_AddState),
    .sum_AddState  (sum_AddState),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result)
  );

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Offer one word, count edges until out_valid (0 = timed out), optionally take it.
  task automatic run_op(input bit idle, input logic [31:0] sout, input logic [27:0] sum,
                        input bit take, output logic [31:0] res, output int lat,
                        output bit busy_ok);
    busy_ok = 1'b1;
    lat     = 0;
    @(negedge clock);
    in_valid      = 1'b1;
    idle_AddState = idle;
    sout_AddState = sout;
    sum_AddState  = sum;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 100 && lat == 0; n++) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clock);
      #1;
      if (out_valid) lat = n;
    end
    if (in_ready) busy_ok = 1'b0;
    res = result;
    if (take) begin
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
    end
    tests_run++;
    if (result !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_result got %h want 00000000", result);
    end
  endtask

  task automatic test_add_one();
    logic [31:0] res;
    int lat;
    bit busy_ok;
    run_op(1'b0, 32'h0000_0000, 28'h800_0000, 1'b1, res, lat, busy_ok);
    tests_run++;
    if (res !== 32'h4000_0000) begin
      tests_failed++;
      $display("[TB] FAIL add_one_result got %h want 40000000", res);
    end
    tests_run++;
    if (lat !== 3) begin
      tests_failed++;
      $display("[TB] FAIL add_one_latency got %0d want 3", lat);
    end
    tests_run++;
    if (busy_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL add_one_in_ready_busy got high want low");
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL add_one_in_ready_after got %b want 1", in_ready);
    end
  endtask

  // out_ready held high throughout: it must have no effect before out_valid.
  task automatic test_cancellation();
    logic [31:0] res;
    int lat;
    bit busy_ok;
    out_ready = 1'b1;
    run_op(1'b0, 32'h0000_0000, 28'h000_0008, 1'b1, res, lat, busy_ok);
    tests_run++;
    if (res !== 32'h3400_0000) begin
      tests_failed++;
      $display("[TB] FAIL cancel_result got %h want 34000000", res);
    end
    tests_run++;
    if (lat !== 25) begin
      tests_failed++;
      $display("[TB] FAIL cancel_latency got %0d want 25", lat);
    end
    tests_run++;
    if (busy_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL cancel_in_ready_busy got high want low");
    end
  endtask

  task automatic test_tie_round();
    logic [31:0] res;
    logic [31:0] want;
    int lat;
    bit busy_ok;
`ifdef NORM_ROUND_EN
    want = 32'h3F80_0002;
`else
    want = 32'h3F80_0001;
`endif
    run_op(1'b0, 32'h0000_0000, 28'h400_000C, 1'b1, res, lat, busy_ok);
    tests_run++;
    if (res !== want) begin
      tests_failed++;
      $display("[TB] FAIL tie_result got %h want %h", res, want);
    end
    tests_run++;
    if (lat !== 2) begin
      tests_failed++;
      $display("[TB] FAIL tie_latency got %0d want 2", lat);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] res;
    int lat;
    bit busy_ok;
    run_op(1'b0, {1'b0, 8'h7F, 23'd0}, 28'h800_0000, 1'b1, res, lat, busy_ok);
    tests_run++;
    if (res !== 32'h7F80_0000) begin
      tests_failed++;
      $display("[TB] FAIL inf_result got %h want 7f800000", res);
    end
    tests_run++;
    if (lat !== 3) begin
      tests_failed++;
      $display("[TB] FAIL inf_latency got %0d want 3", lat);
    end
    run_op(1'b0, {1'b0, 8'h82, 23'd0}, 28'h020_0000, 1'b1, res, lat, busy_ok);
    tests_run++;
    if (res !== 32'h0004_0000) begin
      tests_failed++;
      $display("[TB] FAIL denorm_result got %h want 00040000", res);
    end
    tests_run++;
    if (lat !== 2) begin
      tests_failed++;
      $display("[TB] FAIL denorm_latency got %0d want 2", lat);
    end
    run_op(1'b0, {1'b1, 8'h05, 23'd0}, 28'h000_0000, 1'b1, res, lat, busy_ok);
    tests_run++;
    if (res !== 32'h8000_0000) begin
      tests_failed++;
      $display("[TB] FAIL neg_zero_result got %h want 80000000", res);
    end
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("[TB] FAIL neg_zero_latency got %0d want 1", lat);
    end
  endtask

  // Bypass, then stall the consumer; a new word offered meanwhile is ignored.
  task automatic test_bypass_hold();
    logic [31:0] res;
    int lat;
    bit busy_ok;
    run_op(1'b1, 32'h7FC0_0000, 28'h123_4567, 1'b0, res, lat, busy_ok);
    tests_run++;
    if (res !== 32'h7FC0_0000) begin
      tests_failed++;
      $display("[TB] FAIL bypass_result got %h want 7fc00000", res);
    end
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("[TB] FAIL bypass_latency got %0d want 1", lat);
    end
    in_valid      = 1'b1;
    idle_AddState = 1'b0;
    sum_AddState  = 28'h800_0000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      #1;
      tests_run++;
      if (result !== 32'h7FC0_0000 || out_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL hold_result cycle %0d got %h/%b want 7fc00000/1", c, result, out_valid);
      end
      tests_run++;
      if (in_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL hold_in_ready cycle %0d got %b want 0", c, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL release got in_ready %b out_valid %b want 1/0", in_ready, out_valid);
    end
    repeat (4) @(posedge clock);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL not_queued got out_valid %b in_ready %b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    int lat;
    bit busy_ok;
    @(negedge clock);
    in_valid      = 1'b1;
    idle_AddState = 1'b0;
    sout_AddState = 32'h0000_0000;
    sum_AddState  = 28'h000_0008;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset got out_valid %b in_ready %b want 0/1", out_valid, in_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    run_op(1'b0, 32'h0000_0000, 28'h800_0000, 1'b1, res, lat, busy_ok);
    tests_run++;
    if (res !== 32'h4000_0000) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_result got %h want 40000000", res);
    end
    tests_run++;
    if (lat !== 3) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_latency got %0d want 3", lat);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    in_valid      = 1'b0;
    idle_AddState = 1'b0;
    sout_AddState = 32'h0;
    sum_AddState  = 28'h0;
    out_ready     = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b0;
    test_add_one();
    test_cancellation();
    test_tie_round();
    test_boundaries();
    test_bypass_hold();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
